// File: rtl/sequence_generator.sv
// Serial stimulus source for the 01[0*]1 sequence detector, with a pattern count and 7-seg display.
// Latency: start is taken on the next edge; sig_out, busy and the pulses are flops; the display lags sent_count by 1 cycle.
// Backpressure: none. ena is a bit strobe, and the FSM and counters hold on edges where ena=0.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   ena           bit strobe; a bit state is left only on an edge with ena=1
//   start         single-cycle request, accepted only in IDLE
//   num_patterns  patterns to send (clamped to CNT_MAX)
//   gap_zeros     zeros between the two 1s of each pattern
//   sig_out       serial stream (idle high)
//   busy          high while not IDLE
//   pattern_end   1-cycle pulse after each END1 bit
//   done          1-cycle pulse after the last pattern (or right after a start with n=0)
//   sent_count    patterns completed since the last accepted start
//   disp0/disp1   ones/tens digit of sent_count, active-low 7-seg (gfedcba)
module sequence_generator #(
  parameter int GAP_W    = 4,
  parameter int SEP_ONES = 1,
  parameter int CNT_MAX  = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [6:0]       num_patterns,
  input  logic [GAP_W-1:0] gap_zeros,
  output logic             sig_out,
  output logic             busy,
  output logic             pattern_end,
  output logic             done,
  output logic [6:0]       sent_count,
  output logic [6:0]       disp0,
  output logic [6:0]       disp1
);

  // The separator counter needs at least one bit, even when SEP_ONES is 0 and the SEP state is never entered.
  localparam int               SEP_W     = (SEP_ONES > 1) ? $clog2(SEP_ONES + 1) : 1;
  localparam logic [SEP_W-1:0] SEP_LOAD  = SEP_W'(SEP_ONES);
  localparam logic [6:0]       CNT_MAX_C = 7'(CNT_MAX);
  localparam logic [6:0]       SEG_ZERO  = 7'b1000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD0,
    S_MARK1,
    S_GAP,
    S_END1,
    S_SEP
  } state_t;

  state_t           state;
  logic [6:0]       remaining;
  logic [GAP_W-1:0] gap_cfg;
  logic [GAP_W-1:0] gap_cnt;
  logic [SEP_W-1:0] sep_cnt;
  logic [6:0]       n_clamped;

  assign n_clamped = (num_patterns > CNT_MAX_C) ? CNT_MAX_C : num_patterns;

  // Active-low segment codes, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [6:0] d);
    logic [6:0] s;
    case (d)
      7'd0:    s = 7'b1000000;
      7'd1:    s = 7'b1111001;
      7'd2:    s = 7'b0100100;
      7'd3:    s = 7'b0110000;
      7'd4:    s = 7'b0011001;
      7'd5:    s = 7'b0010010;
      7'd6:    s = 7'b0000010;
      7'd7:    s = 7'b1111000;
      7'd8:    s = 7'b0000000;
      7'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Every output is loaded together with the state it belongs to. As a result,
  // sig_out always shows the bit of the state just entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sig_out     <= 1'b1;
      busy        <= 1'b0;
      pattern_end <= 1'b0;
      done        <= 1'b0;
      sent_count  <= 7'd0;
      remaining   <= 7'd0;
      gap_cfg     <= '0;
      gap_cnt     <= '0;
      sep_cnt     <= '0;
    end else begin
      pattern_end <= 1'b0;
      done        <= 1'b0;
      if (state == S_IDLE) begin
        // A start is taken without ena. A request with n=0 completes at once.
        if (start) begin
          gap_cfg    <= gap_zeros;
          remaining  <= n_clamped;
          sent_count <= 7'd0;
          if (n_clamped == 7'd0) begin
            done <= 1'b1;
          end else begin
            state   <= S_LEAD0;
            sig_out <= 1'b0;
            busy    <= 1'b1;
          end
        end
      end else if (ena) begin
        case (state)
          S_LEAD0: begin
            state   <= S_MARK1;
            sig_out <= 1'b1;
          end
          S_MARK1: begin
            if (gap_cfg == '0) begin
              state   <= S_END1;
              sig_out <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= gap_cfg;
              sig_out <= 1'b0;
            end
          end
          S_GAP: begin
            // The counter holds the number of zero bits still to send, this one included.
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt <= 1) begin
              state   <= S_END1;
              sig_out <= 1'b1;
            end
          end
          S_END1: begin
            pattern_end <= 1'b1;
            sent_count  <= (sent_count >= CNT_MAX_C) ? CNT_MAX_C : sent_count + 7'd1;
            remaining   <= remaining - 7'd1;
            if (remaining <= 7'd1) begin
              // The last pattern has no separator. busy falls in the same cycle as done.
              state   <= S_IDLE;
              sig_out <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (SEP_ONES > 0) begin
              state   <= S_SEP;
              sep_cnt <= SEP_LOAD;
              sig_out <= 1'b1;
            end else begin
              state   <= S_LEAD0;
              sig_out <= 1'b0;
            end
          end
          S_SEP: begin
            sep_cnt <= sep_cnt - 1'b1;
            if (sep_cnt <= 1) begin
              state   <= S_LEAD0;
              sig_out <= 1'b0;
            end
          end
          default: begin
            state   <= S_IDLE;
            sig_out <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // The display follows sent_count on every clock, whatever ena is.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp0 <= SEG_ZERO;
      disp1 <= SEG_ZERO;
    end else begin
      disp0 <= seg7(sent_count % 7'd10);
      disp1 <= seg7(sent_count / 7'd10);
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;

  localparam int SEP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [6:0] num_patterns = 7'd0;
  logic [3:0] gap_zeros = 4'd0;
  logic       sig_out, busy, pattern_end, done;
  logic [6:0] sent_count, disp0, disp1;

  int vectors = 0;
  int miscompares = 0;

  bit exp_q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  sequence_generator #(.GAP_W(4), .SEP_ONES(SEP), .CNT_MAX(99)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .num_patterns(num_patterns),
    .gap_zeros(gap_zeros), .sig_out(sig_out), .busy(busy), .pattern_end(pattern_end),
    .done(done), .sent_count(sent_count), .disp0(disp0), .disp1(disp1)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sig_out !== 1'b1 || busy !== 1'b0 || pattern_end !== 1'b0 || done !== 1'b0)
      begin miscompares++; $display("FAIL reset_ctl: sig=%b busy=%b pe=%b done=%b, want 1 0 0 0", sig_out, busy, pattern_end, done); end
    vectors++;
    if (sent_count !== 7'd0 || disp0 !== 7'b1000000 || disp1 !== 7'b1000000)
      begin miscompares++; $display("FAIL reset_cnt: cnt=%0d d0=%b d1=%b, want 0 1000000 1000000", sent_count, disp0, disp1); end
    rst = 1'b0;
  endtask

  // Sends one run. The expected bit stream is queued when start is driven, and bits are popped as ena edges consume them.
  task automatic run_seq(input int num, input int gap, input bit toggle, input int inject_at, input string name);
    int  n, ends, cnt;
    bit  fin, ena_d;
    n = (num > 99) ? 99 : num;
    for (int p = 0; p < n; p++) begin
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      for (int g = 0; g < gap; g++) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      if (p != n - 1) for (int s = 0; s < SEP; s++) exp_q.push_back(1'b1);
    end
    num_patterns = 7'(num);
    gap_zeros    = 4'(gap);
    start = 1'b1;
    ena   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL %s busy_rise: busy=%b want 1", name, busy); end
    cnt = 0; ends = 0; fin = 0;
    for (int it = 0; it < 6000 && !fin; it++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++; $display("FAIL %s stream_len: sig=%b with no bit expected", name, sig_out);
      end else if (sig_out !== exp_q[0]) begin
        miscompares++; $display("FAIL %s bit%0d: sig=%b want %b", name, it, sig_out, exp_q[0]);
      end
      ena_d = toggle ? it[0] : 1'b1;
      ena = ena_d;
      if (it == inject_at) begin start = 1'b1; num_patterns = 7'd5; end
      @(posedge clk); #1;
      start = 1'b0;
      num_patterns = 7'(num);
      if (ena_d && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pattern_end === 1'b1) begin
        ends++;
        cnt = (cnt < 99) ? cnt + 1 : 99;
        vectors++;
        if (sent_count !== 7'(cnt)) begin miscompares++; $display("FAIL %s sent_count: got %0d want %0d", name, sent_count, cnt); end
      end
      if (busy !== 1'b1) begin
        fin = 1;
        vectors++;
        if (done !== 1'b1 || pattern_end !== 1'b1)
          begin miscompares++; $display("FAIL %s end_pulses: done=%b pe=%b want 1 1", name, done, pattern_end); end
      end
    end
    if (!fin) begin vectors++; miscompares++; $display("FAIL %s timeout: busy still %b", name, busy); end
    vectors++;
    if (ends != n) begin miscompares++; $display("FAIL %s pattern_count: got %0d want %0d", name, ends, n); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL %s leftover: %0d bits unsent", name, exp_q.size()); end
    ena = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (sig_out !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
      begin miscompares++; $display("FAIL %s idle: sig=%b done=%b busy=%b want 1 0 0", name, sig_out, done, busy); end
    vectors++;
    if (disp0 !== seg_tab[cnt % 10] || disp1 !== seg_tab[cnt / 10])
      begin miscompares++; $display("FAIL %s disp: d1=%b d0=%b want %b %b", name, disp1, disp0, seg_tab[cnt / 10], seg_tab[cnt % 10]); end
    exp_q.delete();
  endtask

  task automatic test_single();
    run_seq(1, 0, 1'b0, -1, "single");
  endtask

  task automatic test_three_gap2();
    run_seq(3, 2, 1'b0, -1, "three_gap2");
  endtask

  task automatic test_ena_toggle();
    run_seq(3, 2, 1'b1, -1, "ena_toggle");
  endtask

  task automatic test_zero_and_ignored_start();
    num_patterns = 7'd0;
    gap_zeros = 4'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || sig_out !== 1'b1 || sent_count !== 7'd0)
      begin miscompares++; $display("FAIL zero_n: done=%b busy=%b sig=%b cnt=%0d want 1 0 1 0", done, busy, sig_out, sent_count); end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || sig_out !== 1'b1)
      begin miscompares++; $display("FAIL zero_n_after: done=%b busy=%b sig=%b want 0 0 1", done, busy, sig_out); end
    run_seq(2, 3, 1'b0, 3, "busy_start");
  endtask

  task automatic test_reset_mid_gap();
    num_patterns = 7'd3;
    gap_zeros = 4'd4;
    ena = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (sent_count !== 7'd1 || busy !== 1'b1 || sig_out !== 1'b0)
      begin miscompares++; $display("FAIL pre_rst: cnt=%0d busy=%b sig=%b want 1 1 0", sent_count, busy, sig_out); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || sig_out !== 1'b1 || sent_count !== 7'd0 || pattern_end !== 1'b0)
      begin miscompares++; $display("FAIL mid_rst: busy=%b sig=%b cnt=%0d pe=%b want 0 1 0 0", busy, sig_out, sent_count, pattern_end); end
    vectors++;
    if (disp0 !== 7'b1000000 || disp1 !== 7'b1000000)
      begin miscompares++; $display("FAIL mid_rst_disp: d1=%b d0=%b want 1000000 1000000", disp1, disp0); end
    run_seq(1, 1, 1'b0, -1, "after_rst");
  endtask

  task automatic test_twelve_and_clamp();
    run_seq(12, 5, 1'b0, -1, "twelve");
    vectors++;
    if (disp1 !== 7'b1111001 || disp0 !== 7'b0100100)
      begin miscompares++; $display("FAIL twelve_disp: d1=%b d0=%b want 1111001 0100100", disp1, disp0); end
    run_seq(120, 0, 1'b0, -1, "clamp");
    vectors++;
    if (sent_count !== 7'd99) begin miscompares++; $display("FAIL clamp_cnt: got %0d want 99", sent_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_gap2();
    test_ena_toggle();
    test_zero_and_ignored_start();
    test_reset_mid_gap();
    test_twelve_and_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
